gg_fwd_xform4x4: RTL and testbench

- Consumes the 128-bit macroblock stream from the DMA read / chroma-DC stage: 26 beats/MB, m_last on the final beat.
- Applies the H.264 4x4 forward core transform to every pel block, and a 2x2 Hadamard to the two chroma-DC beats.
- Emits one 256-bit coefficient beat per input beat with block-type sideband, toward the quantiser.
- Fully pipelined; sustains 1 beat/clk with AXI-stream style valid/ready on both sides.

---
 rtl/gg_fwd_xform4x4.sv | 213 +++++++++++++++++++++
 tb/tb_gg_fwd_xform4x4.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gg_fwd_xform4x4.sv
// H.264 4x4 forward core transform / 2x2 chroma-DC Hadamard, 3-stage valid/ready pipeline.
// Optional `GG_XFORM_SYNC_CHK_EN adds a sticky sync_err output for s_last/index disagreement.
module gg_fwd_xform4x4 #(
   parameter int BEATS_PER_MB = 26,
   parameter int CB_DC_IDX    = 23,
   parameter int CR_DC_IDX    = 24,
   parameter int WORD_LEN     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [127:0]          s_data,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [16*WORD_LEN-1:0] m_data,
   output logic [1:0]            m_kind,
   output logic [4:0]            m_idx,
   output logic                  m_last
`ifdef GG_XFORM_SYNC_CHK_EN
   ,
   output logic                  sync_err
`endif
);

   localparam int W = WORD_LEN;
   localparam logic [4:0] LAST_IDX = 5'(BEATS_PER_MB - 1);
   localparam logic [4:0] CB_IDX   = 5'(CB_DC_IDX);
   localparam logic [4:0] CR_IDX   = 5'(CR_DC_IDX);
   localparam logic [1:0] KIND_LUMA = 2'd0;
   localparam logic [1:0] KIND_AC   = 2'd1;
   localparam logic [1:0] KIND_DC   = 2'd2;
   localparam logic [1:0] KIND_NONE = 2'd3;

   // One 1-D pass of the core transform; result packed {y3,y2,y1,y0}.
   function automatic logic [4*W-1:0] fwd4(input logic signed [W-1:0] x0, x1, x2, x3);
      logic signed [W-1:0] y0, y1, y2, y3;
      y0 = x0 + x1 + x2 + x3;
      y1 = (x0 <<< 1) + x1 - x2 - (x3 <<< 1);
      y2 = x0 - x1 - x2 + x3;
      y3 = x0 - (x1 <<< 1) + (x2 <<< 1) - x3;
      return {y3, y2, y1, y0};
   endfunction

   function automatic logic [1:0] kind_of(input logic [4:0] idx);
      logic [1:0] k;
      if (idx < 5'd16) begin
         k = KIND_LUMA;
      end else if (idx == CB_IDX || idx == CR_IDX) begin
         k = KIND_DC;
      end else if (idx <= LAST_IDX) begin
         k = KIND_AC;
      end else begin
         k = KIND_NONE;
      end
      return k;
   endfunction

   logic              s0_valid_r, s1_valid_r, m_valid_r;
   logic [127:0]      s0_data_r;
   logic [16*W-1:0]   s1_coef_r, m_data_r;
   logic [1:0]        s0_kind_r, s1_kind_r, m_kind_r;
   logic [4:0]        s0_idx_r, s1_idx_r, m_idx_r;
   logic              s0_last_r, s1_last_r, m_last_r;
   logic [4:0]        cnt_r, cnt_next_s;
   logic              rdy0_s, rdy1_s, rdy2_s, s0_accept_s;
   logic [16*W-1:0]   s1_next_s, m_next_s;
   logic [4*W-1:0]    pass_s [4];
   logic signed [W-1:0] d_s [4];

   // Back-pressure chain: a stage may load when empty or when it is handing off.
   always_comb begin
      rdy2_s      = !m_valid_r || m_ready;
      rdy1_s      = !s1_valid_r || rdy2_s;
      rdy0_s      = !s0_valid_r || rdy1_s;
      s0_accept_s = s_valid && rdy0_s;
      if (s_last || cnt_r == LAST_IDX) begin
         cnt_next_s = 5'd0;
      end else begin
         cnt_next_s = cnt_r + 5'd1;
      end
   end

   assign s_ready = rdy0_s;

   // Stage-1 compute: row pass over pels, or first Hadamard butterfly over DC sums.
   always_comb begin
      s1_next_s = '0;
      for (int i = 0; i < 4; i++) begin
         pass_s[i] = '0;
         d_s[i]    = {{(W-12){1'b0}}, s0_data_r[32*i +: 12]};
      end
      if (s0_kind_r == KIND_DC) begin
         s1_next_s[0*W +: W] = d_s[0] + d_s[1];
         s1_next_s[1*W +: W] = d_s[0] - d_s[1];
         s1_next_s[2*W +: W] = d_s[2] + d_s[3];
         s1_next_s[3*W +: W] = d_s[2] - d_s[3];
      end else begin
         for (int r = 0; r < 4; r++) begin
            pass_s[r] = fwd4({{(W-8){1'b0}}, s0_data_r[8*(4*r+0) +: 8]},
                             {{(W-8){1'b0}}, s0_data_r[8*(4*r+1) +: 8]},
                             {{(W-8){1'b0}}, s0_data_r[8*(4*r+2) +: 8]},
                             {{(W-8){1'b0}}, s0_data_r[8*(4*r+3) +: 8]});
            s1_next_s[4*W*r +: 4*W] = pass_s[r];
         end
      end
   end

   logic [4*W-1:0] col_s [4];

   // Stage-2 compute: column pass, or second butterfly producing f0..f3.
   always_comb begin
      m_next_s = '0;
      for (int j = 0; j < 4; j++) begin
         col_s[j] = '0;
      end
      if (s1_kind_r == KIND_DC) begin
         m_next_s[0*W +: W] = s1_coef_r[0*W +: W] + s1_coef_r[2*W +: W];
         m_next_s[1*W +: W] = s1_coef_r[1*W +: W] + s1_coef_r[3*W +: W];
         m_next_s[2*W +: W] = s1_coef_r[0*W +: W] - s1_coef_r[2*W +: W];
         m_next_s[3*W +: W] = s1_coef_r[1*W +: W] - s1_coef_r[3*W +: W];
      end else begin
         for (int j = 0; j < 4; j++) begin
            col_s[j] = fwd4(s1_coef_r[(0+j)*W +: W], s1_coef_r[(4+j)*W +: W],
                            s1_coef_r[(8+j)*W +: W], s1_coef_r[(12+j)*W +: W]);
            for (int i = 0; i < 4; i++) begin
               m_next_s[(4*i+j)*W +: W] = col_s[j][i*W +: W];
            end
         end
      end
   end

   // Valid/tag pipeline and beat counter; an s_last beat resyncs the counter to 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r      <= 5'd0;
         s0_valid_r <= 1'b0;
         s1_valid_r <= 1'b0;
         m_valid_r  <= 1'b0;
         s0_kind_r  <= 2'd0;
         s1_kind_r  <= 2'd0;
         m_kind_r   <= 2'd0;
         s0_idx_r   <= 5'd0;
         s1_idx_r   <= 5'd0;
         m_idx_r    <= 5'd0;
         s0_last_r  <= 1'b0;
         s1_last_r  <= 1'b0;
         m_last_r   <= 1'b0;
      end else begin
         if (s0_accept_s) begin
            cnt_r     <= cnt_next_s;
            s0_kind_r <= kind_of(cnt_r);
            s0_idx_r  <= cnt_r;
            s0_last_r <= s_last;
         end
         if (rdy0_s) begin
            s0_valid_r <= s_valid;
         end
         if (rdy1_s) begin
            s1_valid_r <= s0_valid_r;
            if (s0_valid_r) begin
               s1_kind_r <= s0_kind_r;
               s1_idx_r  <= s0_idx_r;
               s1_last_r <= s0_last_r;
            end
         end
         if (rdy2_s) begin
            m_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
               m_kind_r <= s1_kind_r;
               m_idx_r  <= s1_idx_r;
               m_last_r <= s1_last_r;
            end
         end
      end
   end

   // Data registers carry no reset; they only load alongside a valid beat.
   always_ff @(posedge clk) begin
      if (s0_accept_s) begin
         s0_data_r <= s_data;
      end
      if (rdy1_s && s0_valid_r) begin
         s1_coef_r <= s1_next_s;
      end
      if (rdy2_s && s1_valid_r) begin
         m_data_r <= m_next_s;
      end
   end

   assign m_valid = m_valid_r;
   assign m_data  = m_data_r;
   assign m_kind  = m_kind_r;
   assign m_idx   = m_idx_r;
   assign m_last  = m_last_r;

`ifdef GG_XFORM_SYNC_CHK_EN
   logic sync_err_r;

   // Sticky flag: s_last must coincide exactly with the final beat index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_err_r <= 1'b0;
      end else if (s0_accept_s && (s_last != (cnt_r == LAST_IDX))) begin
         sync_err_r <= 1'b1;
      end
   end

   assign sync_err = sync_err_r;
`endif

endmodule

// File: tb/tb_gg_fwd_xform4x4.sv
// Self-checking bench for gg_fwd_xform4x4: matrix-product reference model plus ordered scoreboard.
module tb_gg_fwd_xform4x4;

   logic         clk = 1'b0;
   logic         reset;
   logic         s_valid, s_ready, s_last;
   logic [127:0] s_data;
   logic         m_valid, m_ready, m_last;
   logic [255:0] m_data;
   logic [1:0]   m_kind;
   logic [4:0]   m_idx;
`ifdef GG_XFORM_SYNC_CHK_EN
   logic         sync_err;
`endif

   gg_fwd_xform4x4 dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_kind(m_kind), .m_idx(m_idx), .m_last(m_last)
`ifdef GG_XFORM_SYNC_CHK_EN
      , .sync_err(sync_err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [255:0] data;
      logic [1:0]   kind;
      logic [4:0]   idx;
      logic         last;
      int           edge_n;
   } beat_t;

   beat_t exp_q[$];
   beat_t cap_q[$];
   int    n_vec = 0;
   int    n_fail = 0;
   int    tb_cnt = 0;
   bit    lat_chk = 1'b0;
   int    rdy_mode = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: Y = Cf * X * Cf^T by plain sums, or the 2x2 Hadamard formulas for DC beats.
   function automatic logic [255:0] model_xform(input logic [127:0] d, input int idx);
      int cf [4][4];
      int x [4][4];
      int dd [4];
      int acc;
      logic [255:0] r;
      cf = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
      r = '0;
      if (idx == 23 || idx == 24) begin
         for (int i = 0; i < 4; i++) dd[i] = int'(d[32*i +: 12]);
         r[15:0]  = 16'(dd[0] + dd[1] + dd[2] + dd[3]);
         r[31:16] = 16'(dd[0] - dd[1] + dd[2] - dd[3]);
         r[47:32] = 16'(dd[0] + dd[1] - dd[2] - dd[3]);
         r[63:48] = 16'(dd[0] - dd[1] - dd[2] + dd[3]);
      end else begin
         for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) x[a][b] = int'(d[8*(4*a+b) +: 8]);
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
               acc = 0;
               for (int a = 0; a < 4; a++)
                  for (int b = 0; b < 4; b++) acc += cf[i][a] * x[a][b] * cf[j][b];
               r[16*(4*i+j) +: 16] = 16'(acc);
            end
      end
      return r;
   endfunction

   function automatic logic [1:0] model_kind(input int idx);
      if (idx < 16) return 2'd0;
      if (idx == 23 || idx == 24) return 2'd2;
      return 2'd1;
   endfunction

   function automatic logic [127:0] rand_beat();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] dc_beat(input int d0, input int d1, input int d2, input int d3);
      logic [127:0] r;
      r = rand_beat();
      r[11:0]   = 12'(d0);
      r[43:32]  = 12'(d1);
      r[75:64]  = 12'(d2);
      r[107:96] = 12'(d3);
      return r;
   endfunction

   // Negedge observer: scoreboard, stall stability, input capture into the model.
   task automatic monitor();
      beat_t e;
      logic hv;
      logic [255:0] hd;
      logic [8:0] ht;
      hv = 1'b0; hd = '0; ht = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            hv = 1'b0;
            tb_cnt = 0;
            exp_q.delete();
         end else begin
            if (hv) begin
               chk("stall_data", m_data, hd);
               chk("stall_tag", 256'({m_valid, m_kind, m_idx, m_last}), 256'(ht));
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  n_vec++; n_fail++;
                  $display("FAIL unexpected_output: got idx %0d expected no beat", m_idx);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", m_data, e.data);
                  chk("out_tag", 256'({m_kind, m_idx, m_last}), 256'({e.kind, e.idx, e.last}));
                  if (lat_chk) chk("latency", 256'(cyc + 1), 256'(e.edge_n + 3));
               end
               cap_q.push_back('{m_data, m_kind, m_idx, m_last, cyc + 1});
            end
            hv = m_valid && !m_ready;
            hd = m_data;
            ht = {1'b1, m_kind, m_idx, m_last};
            if (s_valid && s_ready) begin
               e.data   = model_xform(s_data, tb_cnt);
               e.kind   = model_kind(tb_cnt);
               e.idx    = 5'(tb_cnt);
               e.last   = s_last;
               e.edge_n = cyc + 1;
               exp_q.push_back(e);
               tb_cnt = (s_last || tb_cnt == 25) ? 0 : tb_cnt + 1;
            end
         end
      end
   endtask

   task automatic ready_driver();
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
         endcase
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input logic [127:0] d, input logic l);
      int t;
      s_data = d; s_last = l; s_valid = 1'b1;
      t = 0;
      while (1) begin
         @(negedge clk);
         if (s_ready) break;
         t++;
         if (t > 2000) begin
            n_vec++; n_fail++;
            $display("FAIL send_timeout: s_ready 0 expected 1");
            break;
         end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic send_mb(input bit gaps);
      for (int i = 0; i < 26; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         if (i == 23 || i == 24)
            send(dc_beat($urandom_range(0, 4080), $urandom_range(0, 4080),
                         $urandom_range(0, 4080), $urandom_range(0, 4080)), i == 25);
         else
            send(rand_beat(), i == 25);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 5000) begin @(posedge clk); t++; end
      if (exp_q.size() != 0) begin
         n_vec++; n_fail++;
         $display("FAIL drain_timeout: %0d beats outstanding expected 0", exp_q.size());
      end
      idle(4);
   endtask

   initial begin
      int base;
      logic [255:0] pin;
      beat_t c;
      reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
      fork
         monitor();
         ready_driver();
      join_none
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 256'({m_valid, m_kind, m_idx, m_last}), 256'(0));
      chk("reset_s_ready", 256'(s_ready), 256'(1));
`ifdef GG_XFORM_SYNC_CHK_EN
      chk("reset_sync_err", 256'(sync_err), 256'(0));
`endif
      reset = 1'b0;

      // Model pins against hand-computed values.
      pin = model_xform({4{8'd3, 8'd2, 8'd1, 8'd0}}, 1);
      chk("pin_ramp", pin, {192'd0, 16'hFFFC, 16'd0, 16'hFFE4, 16'd24});
      pin = model_xform(dc_beat(100, 200, 300, 400), 23);
      chk("pin_dc", pin, {192'd0, 16'd0, 16'hFE70, 16'hFF38, 16'd1000});

      // Directed MB plus a second MB, back-to-back with m_ready held high.
      idle(2);
      lat_chk = 1'b1;
      base = cap_q.size();
      send({16{8'd10}}, 1'b0);
      send({4{8'd3, 8'd2, 8'd1, 8'd0}}, 1'b0);
      send({16{8'hFF}}, 1'b0);
      for (int i = 3; i < 23; i++) send(rand_beat(), 1'b0);
      send(dc_beat(100, 200, 300, 400), 1'b0);
      send(dc_beat($urandom_range(0, 4080), 7, 4080, 0), 1'b0);
      send(rand_beat(), 1'b1);
      send_mb(1'b0);
      drain();
      lat_chk = 1'b0;
      chk("burst_count", 256'(cap_q.size() - base), 256'(52));
      if (cap_q.size() >= base + 52) begin
         c = cap_q[base];
         chk("flat_coef0", 256'(c.data[15:0]), 256'(160));
         chk("flat_rest", 256'(c.data[255:16]), 256'(0));
         chk("flat_tag", 256'({c.kind, c.idx}), 256'(0));
         c = cap_q[base + 1];
         chk("ramp_coefs", c.data, {192'd0, 16'hFFFC, 16'd0, 16'hFFE4, 16'd24});
         c = cap_q[base + 2];
         chk("all255", c.data, {240'd0, 16'd4080});
         c = cap_q[base + 23];
         chk("dc_coefs", c.data, {192'd0, 16'd0, 16'hFE70, 16'hFF38, 16'd1000});
         chk("dc_kind", 256'(c.kind), 256'(2));
         c = cap_q[base + 25];
         chk("mb0_last", 256'({c.last, c.kind, c.idx}), 256'({1'b1, 2'd1, 5'd25}));
         c = cap_q[base + 51];
         chk("mb1_last", 256'({c.last, c.idx}), 256'({1'b1, 5'd25}));
         chk("consecutive", 256'(cap_q[base + 51].edge_n - cap_q[base].edge_n), 256'(51));
      end
`ifdef GG_XFORM_SYNC_CHK_EN
      chk("sync_ok_clean", 256'(sync_err), 256'(0));
`endif

      // Random back-pressure and input gaps over 4 MBs.
      rdy_mode = 1;
      repeat (4) send_mb(1'b1);
      drain();

      // Early s_last at index 20 resyncs the counter.
      rdy_mode = 0;
      for (int i = 0; i < 21; i++) send(rand_beat(), i == 20);
      send(rand_beat(), 1'b0);
      drain();
      c = cap_q[cap_q.size() - 1];
      chk("resync_idx", 256'(c.idx), 256'(0));
      c = cap_q[cap_q.size() - 2];
      chk("early_last", 256'({c.last, c.idx}), 256'({1'b1, 5'd20}));
`ifdef GG_XFORM_SYNC_CHK_EN
      chk("sync_err_set", 256'(sync_err), 256'(1));
`endif
      rdy_mode = 1;
      for (int i = 1; i < 26; i++) send(rand_beat(), i == 25);
      drain();
`ifdef GG_XFORM_SYNC_CHK_EN
      chk("sync_err_sticky", 256'(sync_err), 256'(1));
`endif

      // Reset with the pipeline full and stalled.
      rdy_mode = 2;
      idle(2);
      for (int i = 0; i < 3; i++) send(rand_beat(), 1'b0);
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      chk("midreset_valid", 256'(m_valid), 256'(0));
`ifdef GG_XFORM_SYNC_CHK_EN
      chk("midreset_sync_err", 256'(sync_err), 256'(0));
`endif
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      rdy_mode = 0;
      idle(2);
      base = cap_q.size();
      send({16{8'd10}}, 1'b0);
      drain();
      chk("post_reset_count", 256'(cap_q.size() - base), 256'(1));
      c = cap_q[cap_q.size() - 1];
      chk("post_reset_idx", 256'({c.idx, c.data[15:0]}), 256'({5'd0, 16'd160}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
